// File: rtl/or4_stimulus_sequencer.sv
// Cycle-exact pattern source for the four-input OR block: steps through a
// selectable 4-bit sequence, holding each pattern HOLD cycles for SWEEPS passes.
module or4_stimulus_sequencer #(
  parameter int HOLD   = 4,
  parameter int SWEEPS = 1,
  parameter int CNT_W  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic       pause,
  input  logic [1:0] mode,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  output logic       step,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] SWEEP_LAST = CNT_W'(SWEEPS - 1);

  state_t           r_state, w_state_nx;
  logic [1:0]       r_mode, w_mode_nx;
  logic [3:0]       r_pat, w_pat_nx;
  logic [3:0]       r_idx, w_idx_nx;
  logic [CNT_W-1:0] r_hold, w_hold_nx;
  logic [CNT_W-1:0] r_sweep, w_sweep_nx;
  logic             r_step, w_step_nx;
  logic             r_busy, w_busy_nx;
  logic             r_done, w_done_nx;
  logic [3:0]       w_idx_inc;

  function automatic logic [3:0] f_first(input logic [1:0] md);
    return (md == 2'd1 || md == 2'd3) ? 4'b0001 : 4'b0000;
  endfunction

  // r_idx counts position within a pass, so the last pattern is a fixed index per mode.
  function automatic logic [3:0] f_last_idx(input logic [1:0] md);
    case (md)
      2'd1:    return 4'd3;
      2'd3:    return 4'd14;
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [3:0] f_next(input logic [1:0] md, input logic [3:0] idx_nx,
                                        input logic [3:0] pat);
    case (md)
      2'd0:    return idx_nx;
      2'd1:    return {pat[2:0], 1'b0};
      2'd2:    return idx_nx ^ {1'b0, idx_nx[3:1]};
      default: return {pat[2:0], pat[3] ^ pat[2]};
    endcase
  endfunction

  assign w_idx_inc = r_idx + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_mode  <= 2'd0;
      r_pat   <= 4'd0;
      r_idx   <= 4'd0;
      r_hold  <= '0;
      r_sweep <= '0;
      r_step  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_mode  <= w_mode_nx;
      r_pat   <= w_pat_nx;
      r_idx   <= w_idx_nx;
      r_hold  <= w_hold_nx;
      r_sweep <= w_sweep_nx;
      r_step  <= w_step_nx;
      r_busy  <= w_busy_nx;
      r_done  <= w_done_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_mode_nx  = r_mode;
    w_pat_nx   = r_pat;
    w_idx_nx   = r_idx;
    w_hold_nx  = r_hold;
    w_sweep_nx = r_sweep;
    w_step_nx  = 1'b0;
    w_busy_nx  = r_busy;
    w_done_nx  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_pat_nx  = 4'd0;
        w_busy_nx = 1'b0;
        if (start && !abort) begin
          w_state_nx = S_RUN;
          w_mode_nx  = mode;
          w_pat_nx   = f_first(mode);
          w_idx_nx   = 4'd0;
          w_hold_nx  = '0;
          w_sweep_nx = '0;
          w_step_nx  = 1'b1;
          w_busy_nx  = 1'b1;
        end
      end
      S_RUN: begin
        if (abort) begin
          w_state_nx = S_IDLE;
          w_pat_nx   = 4'd0;
          w_idx_nx   = 4'd0;
          w_hold_nx  = '0;
          w_sweep_nx = '0;
          w_busy_nx  = 1'b0;
        end else if (pause) begin
          w_step_nx = 1'b0;
        end else if (r_hold < HOLD_LAST) begin
          w_hold_nx = r_hold + 1'b1;
        end else if (r_idx < f_last_idx(r_mode)) begin
          w_idx_nx  = w_idx_inc;
          w_pat_nx  = f_next(r_mode, w_idx_inc, r_pat);
          w_hold_nx = '0;
          w_step_nx = 1'b1;
        end else if (r_sweep < SWEEP_LAST) begin
          w_idx_nx   = 4'd0;
          w_pat_nx   = f_first(r_mode);
          w_hold_nx  = '0;
          w_sweep_nx = r_sweep + 1'b1;
          w_step_nx  = 1'b1;
        end else begin
          w_state_nx = S_DONE;
          w_pat_nx   = 4'd0;
          w_idx_nx   = 4'd0;
          w_hold_nx  = '0;
          w_sweep_nx = '0;
          w_busy_nx  = 1'b0;
          w_done_nx  = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
        w_pat_nx   = 4'd0;
        w_busy_nx  = 1'b0;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_pat_nx   = 4'd0;
        w_busy_nx  = 1'b0;
      end
    endcase
  end

  assign {a, b, c, d} = r_pat;
  assign step = r_step;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_or4_stimulus_sequencer.sv
// Three sequencers (different HOLD/SWEEPS) share one stimulus stream and are
// each compared every cycle against a run-progress model of the sequence rules.
module tb_or4_stimulus_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       pause = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [2:0] a_w, b_w, c_w, d_w, step_w, busy_w, done_w;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int H = (g == 0) ? 4 : (g == 1) ? 2 : 1;
    localparam int S = (g == 1) ? 2 : 1;
    or4_stimulus_sequencer #(.HOLD(H), .SWEEPS(S), .CNT_W(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .pause(pause),
      .mode(mode), .a(a_w[g]), .b(b_w[g]), .c(c_w[g]), .d(d_w[g]),
      .step(step_w[g]), .busy(busy_w[g]), .done(done_w[g])
    );
  end

  // Model state per instance: 0 idle, 1 run, 2 done; m_e counts unpaused RUN cycles.
  int         m_hold[3] = '{4, 2, 1};
  int         m_sweeps[3] = '{1, 2, 1};
  int         m_st[3];
  int         m_e[3];
  int         m_mode[3];
  logic [6:0] m_out[3];

  function automatic int seq_len(input int md);
    case (md)
      0, 2:    return 16;
      1:       return 4;
      default: return 15;
    endcase
  endfunction

  function automatic logic [3:0] seq_pat(input int md, input int k);
    logic [3:0] p;
    case (md)
      0: p = 4'(k);
      1: p = 4'(1 << k);
      2: p = 4'(k ^ (k >> 1));
      default: begin
        p = 4'b0001;
        for (int j = 0; j < k; j++) p = {p[2:0], p[3] ^ p[2]};
      end
    endcase
    return p;
  endfunction

  function automatic logic [6:0] observed(input int i);
    return {a_w[i], b_w[i], c_w[i], d_w[i], step_w[i], busy_w[i], done_w[i]};
  endfunction

  task automatic chk_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_st[i] = 0; m_e[i] = 0; m_mode[i] = 0; m_out[i] = 7'd0;
    end
  endtask

  task automatic model_step(input int i);
    int total;
    case (m_st[i])
      0: begin
        m_out[i] = 7'd0;
        if (start && !abort) begin
          m_st[i] = 1; m_e[i] = 0; m_mode[i] = int'(mode);
          m_out[i] = {seq_pat(m_mode[i], 0), 3'b110};
        end
      end
      1: begin
        total = seq_len(m_mode[i]) * m_hold[i] * m_sweeps[i];
        if (abort) begin
          m_st[i] = 0; m_out[i] = 7'd0;
        end else if (pause) begin
          m_out[i][2] = 1'b0;
        end else begin
          m_e[i]++;
          if (m_e[i] == total) begin
            m_st[i] = 2; m_out[i] = 7'b0000001;
          end else begin
            m_out[i] = {seq_pat(m_mode[i], (m_e[i] / m_hold[i]) % seq_len(m_mode[i])),
                        (m_e[i] % m_hold[i]) == 0, 2'b10};
          end
        end
      end
      default: begin
        m_st[i] = 0; m_out[i] = 7'd0;
      end
    endcase
  endtask

  task automatic cyc(input logic st, input logic ab, input logic pa, input logic [1:0] md);
    start = st; abort = ab; pause = pa; mode = md;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      model_step(i);
      chk_val($sformatf("out%0d", i), {1'b0, observed(i)}, {1'b0, m_out[i]});
    end
  endtask

  task automatic run_to_idle(input int limit);
    int n = 0;
    while ((m_st[0] != 0 || m_st[1] != 0 || m_st[2] != 0) && n < limit) begin
      cyc(1'b0, 1'b0, 1'b0, mode);
      n++;
    end
    chk_val("idle_wait", {5'd0, m_st[2] == 0, m_st[1] == 0, m_st[0] == 0}, 8'b0000_0111);
  endtask

  // Advance until instance 0 shows pattern p in the first cycle of that pattern.
  task automatic run_to_pat0(input logic [3:0] p, input int limit);
    int n = 0;
    while (!(m_out[0][6:3] == p && m_out[0][2]) && n < limit) begin
      cyc(1'b0, 1'b0, 1'b0, mode);
      n++;
    end
    chk_val("pat_wait", {4'd0, m_out[0][6:3]}, {4'd0, p});
  endtask

  initial begin
    model_reset();
    #3;
    for (int i = 0; i < 3; i++) chk_val($sformatf("rst%0d", i), {1'b0, observed(i)}, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) cyc(1'b0, 1'b0, 1'b0, 2'd0);

    // One full run in every mode.
    for (int m = 0; m < 4; m++) begin
      cyc(1'b1, 1'b0, 1'b0, 2'(m));
      run_to_idle(200);
      repeat (2) cyc(1'b0, 1'b0, 1'b0, 2'd0);
    end

    // Gray run: stretch 0011 with a 3-cycle pause, then abort while pausing.
    cyc(1'b1, 1'b0, 1'b0, 2'd2);
    run_to_pat0(4'b0011, 40);
    cyc(1'b0, 1'b0, 1'b0, 2'd2);
    repeat (3) cyc(1'b0, 1'b0, 1'b1, 2'd2);
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 2'd2);
    cyc(1'b0, 1'b1, 1'b1, 2'd2);
    run_to_idle(200);

    // start with abort in IDLE, then start and mode changes during RUN.
    cyc(1'b1, 1'b1, 1'b0, 2'd0);
    cyc(1'b1, 1'b0, 1'b0, 2'd1);
    for (int k = 0; k < 6; k++) cyc(1'b1, 1'b0, 1'b0, 2'(k));
    run_to_idle(200);

    // Randomised control traffic.
    for (int k = 0; k < 1500; k++)
      cyc($urandom_range(0, 7) == 0, $urandom_range(0, 39) == 0,
          $urandom_range(0, 3) == 0, 2'($urandom_range(0, 3)));
    cyc(1'b0, 1'b1, 1'b0, 2'd0);
    run_to_idle(200);

    // Asynchronous reset in the middle of a binary run at pattern 0101.
    cyc(1'b1, 1'b0, 1'b0, 2'd0);
    run_to_pat0(4'b0101, 60);
    cyc(1'b0, 1'b0, 1'b0, 2'd0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 3; i++) chk_val($sformatf("async_rst%0d", i), {1'b0, observed(i)}, 8'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    repeat (4) cyc(1'b0, 1'b0, 1'b0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
